// File: rtl/alu_operand_stage_pkg.sv
// Shared definitions for the ALU operand stage: default sizes and the ALU opcode encoding.
package alu_operand_stage_pkg;

  localparam int unsigned DefWidth   = 8;
  localparam int unsigned DefNumRegs = 16;
  localparam int unsigned DefOpW     = 4;

  typedef enum logic [DefOpW-1:0] {
    OpLsh = 4'b0000,
    OpRsh = 4'b0001,
    OpAnd = 4'b0010,
    OpOr  = 4'b0011,
    OpGeq = 4'b1000,
    OpEq  = 4'b1001,
    OpNeg = 4'b1010,
    OpAdd = 4'b1011,
    OpNeq = 4'b1101
  } op_t;

endpackage

// File: rtl/alu_operand_stage_if.sv
// Issue, write-back and ALU-side signals of the operand stage, bundled as one interface.
interface alu_operand_stage_if
  import alu_operand_stage_pkg::*;
#(
  parameter int unsigned WIDTH    = DefWidth,
  parameter int unsigned NUM_REGS = DefNumRegs,
  parameter int unsigned OP_W     = DefOpW
);

  localparam int unsigned AddrW = $clog2(NUM_REGS);

  // Issue side (from decode)
  logic             InValid;
  logic             InReady;
  logic [OP_W-1:0]  OpIn;
  logic [AddrW-1:0] RaAddr;
  logic [AddrW-1:0] RbAddr;
  logic             ImmSel;
  logic [WIDTH-1:0] Imm;

  // Write-back side
  logic             WrEn;
  logic [AddrW-1:0] WrAddr;
  logic [WIDTH-1:0] WrData;

  // ALU side
  logic             OutValid;
  logic             OutReady;
  logic [WIDTH-1:0] InputA;
  logic [WIDTH-1:0] InputB;
  logic [OP_W-1:0]  OP;

  modport master (
    output InValid, OpIn, RaAddr, RbAddr, ImmSel, Imm,
    output WrEn, WrAddr, WrData,
    output OutReady,
    input  InReady, OutValid, InputA, InputB, OP
  );

  modport slave (
    input  InValid, OpIn, RaAddr, RbAddr, ImmSel, Imm,
    input  WrEn, WrAddr, WrData,
    input  OutReady,
    output InReady, OutValid, InputA, InputB, OP
  );

endinterface

// File: rtl/alu_operand_stage_reg_file.sv
// Architectural register file: two asynchronous read ports, one synchronous write port,
// R0 reads as zero and ignores writes.
module alu_operand_stage_reg_file
  import alu_operand_stage_pkg::*;
#(
  parameter int unsigned WIDTH    = DefWidth,
  parameter int unsigned NUM_REGS = DefNumRegs,
  localparam int unsigned AddrW   = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AddrW-1:0] wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AddrW-1:0] rd_addr_a,
  output logic [WIDTH-1:0] rd_data_a,
  input  logic [AddrW-1:0] rd_addr_b,
  output logic [WIDTH-1:0] rd_data_b
);

  logic [WIDTH-1:0] regs_q [NUM_REGS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en && (wr_addr != '0)) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  // R0 is decoded to zero on read so its storage never matters.
  always_comb begin
    rd_data_a = '0;
    rd_data_b = '0;
    if (rd_addr_a != '0) rd_data_a = regs_q[rd_addr_a];
    if (rd_addr_b != '0) rd_data_b = regs_q[rd_addr_b];
  end

endmodule

// File: rtl/alu_operand_stage.sv
// Operand stage in front of the ALU: register read with write-back forwarding, optional
// immediate on B, and a single-entry valid/ready pipeline register holding InputA/InputB/OP.
module alu_operand_stage
  import alu_operand_stage_pkg::*;
#(
  parameter int unsigned WIDTH    = DefWidth,
  parameter int unsigned NUM_REGS = DefNumRegs,
  parameter int unsigned OP_W     = DefOpW,
  localparam int unsigned AddrW   = $clog2(NUM_REGS)
) (
  input logic               Clk,
  input logic               Reset,
  alu_operand_stage_if.slave bus
);

  logic [WIDTH-1:0] rd_a, rd_b;
  logic [WIDTH-1:0] src_a, src_b;
  logic             fwd_a, fwd_b;
  logic             load;

  logic             out_valid_q;
  logic [WIDTH-1:0] input_a_q, input_b_q;
  logic [OP_W-1:0]  op_q;

  alu_operand_stage_reg_file #(
    .WIDTH   (WIDTH),
    .NUM_REGS(NUM_REGS)
  ) u_reg_file (
    .clk      (Clk),
    .reset    (Reset),
    .wr_en    (bus.WrEn),
    .wr_addr  (bus.WrAddr),
    .wr_data  (bus.WrData),
    .rd_addr_a(bus.RaAddr),
    .rd_data_a(rd_a),
    .rd_addr_b(bus.RbAddr),
    .rd_data_b(rd_b)
  );

  // Forward the same-cycle write-back so a loading instruction sees the newest value.
  always_comb begin
    fwd_a = bus.WrEn && (bus.WrAddr == bus.RaAddr) && (bus.RaAddr != '0);
    fwd_b = bus.WrEn && (bus.WrAddr == bus.RbAddr) && (bus.RbAddr != '0);
    src_a = fwd_a ? bus.WrData : rd_a;
    src_b = fwd_b ? bus.WrData : rd_b;
    if (bus.ImmSel) src_b = bus.Imm;
  end

  assign bus.InReady = !out_valid_q || bus.OutReady;
  assign load        = bus.InValid && bus.InReady;

  // Held operands are snapshots: a write-back during a stall does not touch them.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      out_valid_q <= 1'b0;
      input_a_q   <= '0;
      input_b_q   <= '0;
      op_q        <= '0;
    end else if (load) begin
      out_valid_q <= 1'b1;
      input_a_q   <= src_a;
      input_b_q   <= src_b;
      op_q        <= bus.OpIn;
    end else if (bus.OutReady) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.OutValid = out_valid_q;
  assign bus.InputA   = input_a_q;
  assign bus.InputB   = input_b_q;
  assign bus.OP       = op_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed self-checking bench for alu_operand_stage.
module tb_alu_operand_stage;
  import alu_operand_stage_pkg::*;

  logic Clk = 1'b0;
  logic Reset;
  int   checks = 0;
  int   errors = 0;
  bit   done   = 1'b0;

  always #5 Clk = ~Clk;

  alu_operand_stage_if #(.WIDTH(8), .NUM_REGS(16), .OP_W(4)) bus ();

  alu_operand_stage #(.WIDTH(8), .NUM_REGS(16), .OP_W(4)) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [3:0] ra, input logic [3:0] rb,
                       input logic imm_sel, input logic [7:0] imm);
    bus.InValid = 1'b1;
    bus.OpIn    = op;
    bus.RaAddr  = ra;
    bus.RbAddr  = rb;
    bus.ImmSel  = imm_sel;
    bus.Imm     = imm;
  endtask

  task automatic write_back(input logic en, input logic [3:0] addr, input logic [7:0] data);
    bus.WrEn   = en;
    bus.WrAddr = addr;
    bus.WrData = data;
  endtask

  logic [3:0] b2b_op [4];
  logic [3:0] b2b_ra [4];
  logic [3:0] b2b_rb [4];
  logic       b2b_is [4];
  logic [7:0] b2b_im [4];
  logic [7:0] b2b_ea [4];
  logic [7:0] b2b_eb [4];

  initial begin
    #100000;
    if (!done) begin
      errors++;
      $error("FAIL timeout waiting for test sequence to complete");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  initial begin
    Reset = 1'b1;
    bus.InValid = 1'b0; bus.OpIn = '0; bus.RaAddr = '0; bus.RbAddr = '0;
    bus.ImmSel = 1'b0; bus.Imm = '0; bus.OutReady = 1'b1;
    write_back(1'b0, 4'd0, 8'h00);
    tick(); tick();
    Reset = 1'b0;
    chk("reset_valid", bus.OutValid, 1'b0);
    chk("reset_a", bus.InputA, 8'h00);
    chk("reset_b", bus.InputB, 8'h00);
    chk("reset_op", bus.OP, 4'b0000);
    chk("reset_inready", bus.InReady, 1'b1);

    // Basic ADD from registers
    write_back(1'b1, 4'd1, 8'h05); tick();
    write_back(1'b1, 4'd2, 8'h03); tick();
    write_back(1'b0, 4'd0, 8'h00);
    issue(OpAdd, 4'd1, 4'd2, 1'b0, 8'h00);
    tick();
    bus.InValid = 1'b0;
    chk("add_valid", bus.OutValid, 1'b1);
    chk("add_a", bus.InputA, 8'h05);
    chk("add_b", bus.InputB, 8'h03);
    chk("add_op", bus.OP, 4'b1011);

    // Forwarding of a same-cycle write-back
    write_back(1'b1, 4'd3, 8'hAA);
    issue(OpOr, 4'd3, 4'd3, 1'b0, 8'h00);
    tick();
    write_back(1'b0, 4'd0, 8'h00);
    chk("fwd_a", bus.InputA, 8'hAA);
    chk("fwd_b", bus.InputB, 8'hAA);
    chk("fwd_op", bus.OP, 4'b0011);
    issue(OpAnd, 4'd3, 4'd0, 1'b0, 8'h00);
    tick();
    bus.InValid = 1'b0;
    chk("r3_stored", bus.InputA, 8'hAA);
    chk("r0_read_b", bus.InputB, 8'h00);

    // R0 write ignored, immediate on B, no forwarding onto R0
    write_back(1'b1, 4'd0, 8'hFF);
    tick();
    chk("idle_valid", bus.OutValid, 1'b0);
    issue(OpLsh, 4'd0, 4'd1, 1'b1, 8'h7F);
    tick();
    write_back(1'b0, 4'd0, 8'h00);
    bus.InValid = 1'b0; bus.ImmSel = 1'b0;
    chk("imm_a_r0", bus.InputA, 8'h00);
    chk("imm_b", bus.InputB, 8'h7F);
    chk("imm_op", bus.OP, 4'b0000);

    // Stall: held entry is a snapshot while R1 is rewritten
    issue(OpAdd, 4'd1, 4'd2, 1'b0, 8'h00);
    tick();
    bus.OutReady = 1'b0;
    issue(OpEq, 4'd1, 4'd2, 1'b0, 8'h00);
    write_back(1'b1, 4'd1, 8'h09);
    #1;
    chk("stall_inready", bus.InReady, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      write_back(1'b0, 4'd0, 8'h00);
      chk("stall_valid", bus.OutValid, 1'b1);
      chk("stall_a", bus.InputA, 8'h05);
      chk("stall_b", bus.InputB, 8'h03);
      chk("stall_op", bus.OP, 4'b1011);
      chk("stall_inready_hold", bus.InReady, 1'b0);
    end
    bus.OutReady = 1'b1;
    #1;
    chk("unstall_inready", bus.InReady, 1'b1);
    tick();
    chk("unstall_valid", bus.OutValid, 1'b1);
    chk("unstall_a", bus.InputA, 8'h09);
    chk("unstall_b", bus.InputB, 8'h03);
    chk("unstall_op", bus.OP, 4'b1001);

    // Back-to-back issue with OutReady held high
    b2b_op = '{4'b0000, 4'b0001, 4'b1101, 4'b1000};
    b2b_ra = '{4'd1, 4'd2, 4'd3, 4'd0};
    b2b_rb = '{4'd2, 4'd3, 4'd0, 4'd1};
    b2b_is = '{1'b0, 1'b0, 1'b1, 1'b0};
    b2b_im = '{8'h00, 8'h00, 8'h11, 8'h00};
    b2b_ea = '{8'h09, 8'h03, 8'hAA, 8'h00};
    b2b_eb = '{8'h03, 8'hAA, 8'h11, 8'h09};
    for (int i = 0; i < 4; i++) begin
      issue(b2b_op[i], b2b_ra[i], b2b_rb[i], b2b_is[i], b2b_im[i]);
      #1;
      chk("b2b_inready", bus.InReady, 1'b1);
      tick();
      chk("b2b_valid", bus.OutValid, 1'b1);
      chk("b2b_a", bus.InputA, b2b_ea[i]);
      chk("b2b_b", bus.InputB, b2b_eb[i]);
      chk("b2b_op", bus.OP, b2b_op[i]);
    end
    bus.InValid = 1'b0; bus.ImmSel = 1'b0;
    tick();
    chk("b2b_drain", bus.OutValid, 1'b0);

    // Reset mid-stall wins over InValid and WrEn
    issue(OpAdd, 4'd1, 4'd2, 1'b0, 8'h00);
    tick();
    bus.InValid = 1'b0; bus.OutReady = 1'b0;
    tick();
    chk("pre_reset_valid", bus.OutValid, 1'b1);
    Reset = 1'b1;
    issue(OpNeg, 4'd1, 4'd2, 1'b0, 8'h00);
    write_back(1'b1, 4'd4, 8'h55);
    tick();
    Reset = 1'b0;
    bus.InValid = 1'b0;
    write_back(1'b0, 4'd0, 8'h00);
    chk("rst_valid", bus.OutValid, 1'b0);
    chk("rst_a", bus.InputA, 8'h00);
    chk("rst_b", bus.InputB, 8'h00);
    chk("rst_op", bus.OP, 4'b0000);
    bus.OutReady = 1'b1;
    issue(OpAdd, 4'd1, 4'd4, 1'b0, 8'h00);
    tick();
    bus.InValid = 1'b0;
    chk("rst_r1_cleared", bus.InputA, 8'h00);
    chk("rst_r4_not_written", bus.InputB, 8'h00);

    done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Pipeline stage directly upstream of the ALU.
- Holds the architectural register file and reads two source registers per issued instruction.
- Applies write-back forwarding and an optional immediate on operand B.
- Presents registered InputA/InputB/OP to the ALU, using a valid/ready handshake for stall.

Parameters:
- WIDTH, 8, data width of registers and operands (matches ALU InputA/InputB).
- NUM_REGS, 16, number of architectural registers; address width is $clog2(NUM_REGS).
- OP_W, 4, ALU opcode width (matches ALU OP).

Ports:
- Clk  input  1  single clock.
- Reset  input  1  synchronous, active-high.
- InValid  input  1  upstream decode presents an instruction.
- InReady  output  1  stage can accept this cycle.
- OpIn  input  OP_W  ALU opcode (op_t from definitions).
- RaAddr  input  4  source register for operand A.
- RbAddr  input  4  source register for operand B.
- ImmSel  input  1  1: operand B = Imm; 0: operand B = R[RbAddr].
- Imm  input  WIDTH  immediate value.
- WrEn  input  1  write-back enable from the stage downstream of the ALU.
- WrAddr  input  4  write-back register.
- WrData  input  WIDTH  write-back data.
- OutValid  output  1  InputA/InputB/OP are valid for the ALU.
- OutReady  input  1  ALU/execute consumes this cycle.
- InputA  output  WIDTH  operand A to ALU.
- InputB  output  WIDTH  operand B to ALU.
- OP  output  OP_W  opcode to ALU.

Behaviour:
- Clock and reset: one clock (Clk); Reset is synchronous and active-high.
- Reset state: all registers are 0, OutValid=0, InputA=0, InputB=0, OP=4'b0000. Reset asserted mid-transfer discards any held operands; reset has priority over WrEn and InValid in the same cycle.
- R0: reads always return 0; writes to R0 are ignored.
- Register write: on posedge, if WrEn && WrAddr!=0, R[WrAddr] <= WrData. Write-back proceeds regardless of stall.
- Read with forwarding (combinational): srcA = (WrEn && WrAddr==RaAddr && RaAddr!=0) ? WrData : R[RaAddr]. srcB is formed the same way for RbAddr, then srcB is replaced by Imm when ImmSel=1.
- Handshake:
  - InReady = !OutValid || OutReady (single-entry pipeline register, no combinational path from InValid to InReady).
  - Load = InValid && InReady.
  - On Load: InputA<=srcA, InputB<=srcB, OP<=OpIn, OutValid<=1.
  - Else if OutReady: OutValid<=0.
  - Else: hold all outputs unchanged (stall).
- Throughput and latency: one instruction per cycle when OutReady is held high; latency from input acceptance to OutValid is 1 cycle.
- Stall semantics: held operands are snapshots. A write-back during a stall does NOT update InputA/InputB already captured (hazard detection lives in the decode stage).
- Simultaneous events:
  - OutReady && InValid in the same cycle: the old entry leaves and the new entry loads; OutValid stays 1.
  - WrEn to the same register being read by the loading instruction: the forwarded WrData is captured.
- Opcode passthrough: undefined opcodes are passed unchanged; this stage does no op checking.
- Width: no arithmetic in this block; Imm is used as-is (full WIDTH, no extension).

Decomposition:
- definitions package:
  - op_t enum: LSH=0000, RSH=0001, AND=0010, OR=0011, GEQ=1000, EQ=1001, NEG=1010, ADD=1011, NEQ=1101.
  - WIDTH and NUM_REGS defaults.
- One sub-module, reg_file:
  - NUM_REGS x WIDTH storage, two async read ports, one sync write port, R0 hard-zero.
  - Forwarding and the pipeline register stay in alu_operand_stage.

Test Plan:
- Reset then write R1=0x05, R2=0x03; issue ADD(1011) Ra=1, Rb=2, ImmSel=0, OutReady=1 -> next cycle OutValid=1, InputA=0x05, InputB=0x03, OP=1011.
- Forwarding: same cycle WrEn, WrAddr=3, WrData=0xAA and issue Ra=3, Rb=3 -> InputA=InputB=0xAA; R3 reads 0xAA afterwards.
- Immediate and R0: write R0=0xFF then issue Ra=0, ImmSel=1, Imm=0x7F, OP=0000 -> InputA=0x00, InputB=0x7F.
- Stall: OutReady=0 with entry held (A=0x05), new InValid presented, WrEn writes R1=0x09 -> InReady=0, outputs stay 0x05/0x03 for 3 cycles; on OutReady=1 the new instruction loads in the next cycle.
- Back-to-back: 4 instructions with OutReady=1 -> 4 consecutive OutValid cycles, outputs in order, InReady constantly 1.
- Reset mid-stall: entry held with OutValid=1, Reset=1 for one cycle -> OutValid=0, InputA=InputB=0, OP=0000, R1 reads 0.
